// File: rtl/shared_divider_pkg.sv
// Common bike-computer definitions shared by the divider and its requesters.
package shared_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH   = 16;
  localparam int DIV_LATENCY = DIV_WIDTH + 1;

  localparam logic SEL_SPEED = 1'b0;
  localparam logic SEL_AVG   = 1'b1;

endpackage

// File: rtl/shared_divider.sv
// Shared multi-cycle unsigned restoring divider serving two requesters.
// One quotient bit per cycle; result announced by a one-cycle ready pulse.
module shared_divider
  import shared_divider_pkg::*;
#(
  parameter int               WIDTH    = DIV_WIDTH,
  parameter logic [WIDTH-1:0] DBZ_QUOT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             select,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             owner
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  // dvd_w shifts left each cycle; freed LSBs collect quotient bits
  logic [WIDTH-1:0] dvd_w;
  logic [WIDTH-1:0] dvs_w;
  logic [WIDTH-1:0] rem_w;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_next;
  logic             qbit;
  logic [WIDTH-1:0] quo_next;

  // Single restoring iteration: shift in next dividend bit, trial subtract
  always_comb begin
    shifted = {rem_w, dvd_w[WIDTH-1]};
    if (shifted >= {1'b0, dvs_w}) begin
      rem_next = WIDTH'(shifted - {1'b0, dvs_w});
      qbit     = 1'b1;
    end else begin
      rem_next = shifted[WIDTH-1:0];
      qbit     = 1'b0;
    end
    quo_next = {dvd_w[WIDTH-2:0], qbit};
  end

  // Control FSM, working registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_w       <= '0;
      dvs_w       <= '0;
      rem_w       <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      owner       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          ready <= 1'b0;
          if (start) begin
            dvd_w       <= select ? dividend1 : dividend0;
            dvs_w       <= select ? divisor1 : divisor0;
            owner       <= select;
            div_by_zero <= 1'b0;
            cnt         <= CNT_LOAD;
            rem_w       <= '0;
            busy        <= 1'b1;
            state       <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (dvs_w == '0) begin
            // Requesters still see busy for this one cycle
            quotient    <= DBZ_QUOT;
            remainder   <= dvd_w;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            ready       <= 1'b1;
            state       <= DONE;
          end else begin
            dvd_w <= quo_next;
            rem_w <= rem_next;
            cnt   <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              quotient  <= quo_next;
              remainder <= rem_next;
              busy      <= 1'b0;
              ready     <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
